pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 ADDRESS_WIDTH, 32, width of PC and all address ports.
REQ-002 RESET_VECTOR, 32'h0, PC value loaded on reset.
REQ-003 RAS_DEPTH, 4, return-address-stack entries (power of two, >=2).
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold PC and RAS this cycle.
REQ-007 halt_req / resume  in  1 each  enter / leave HALT state.
REQ-008 redirect_valid  in  1  execute-stage correction (mispredict, jalr resolve, trap).
REQ-009 redirect_pc  in  ADDRESS_WIDTH  corrected target.
REQ-010 pc_src  in  1  taken branch/jal at fetch; target = PC + imm_op.
REQ-011 imm_op  in  ADDRESS_WIDTH  sign-extended offset.
REQ-012 is_call / is_ret  in  1 each  predicted call (push PC+4) / return (pop target).
REQ-013 ras_flush  in  1  clear RAS (count to 0).
REQ-014 pc  out  ADDRESS_WIDTH  current fetch PC (registered).
REQ-015 pc_plus4  out  ADDRESS_WIDTH  pc + 4, combinational, link value for jal/jalr.
REQ-016 halted  out  1  high while in HALT.
REQ-017 ras_empty / ras_full  out  1 each  RAS occupancy flags (combinational from count).
REQ-018 ras_underflow  out  1  one-cycle pulse when is_ret accepted with RAS empty.

Function
REQ-019 FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally next cycle, PC held at RESET_VECTOR during BOOT.
REQ-020 RUN -> HALT when halt_req and not redirect_valid; HALT -> RUN when resume; halt_req and resume together in RUN: stay RUN.
REQ-021 Next-PC priority in RUN: redirect_valid > stall > (is_ret & !ras_empty) > pc_src > pc+4.
REQ-022 redirect_valid in HALT loads redirect_pc and stays HALT; otherwise HALT holds pc.
REQ-023 redirect_pc and RAS targets have bit 0 forced to 0 before loading pc.
REQ-024 All adds modulo 2^ADDRESS_WIDTH; pc+4 and pc+imm_op wrap silently.
REQ-025 Latency: selected next PC appears on pc one cycle after the inputs are sampled.
REQ-026 RAS ops accepted only in RUN with !stall and !redirect_valid; ignored otherwise.
REQ-027 Push writes pc_plus4 at top; count increments, saturating at RAS_DEPTH.
REQ-028 Push when full overwrites oldest entry (circular pointer); ras_full stays high.
REQ-029 Pop returns top entry as next PC, decrements count; pop when empty: no state change, next PC per lower priority, ras_underflow pulses.
REQ-030 is_call and is_ret same cycle: pop target used as next PC, then PC+4 written into the freed slot; count unchanged (if empty: underflow pulse, push proceeds).
REQ-031 ras_flush zeroes count the same cycle, takes precedence over push/pop, and does not affect PC selection except that is_ret sees pre-flush contents.

Reset
REQ-032 rst_n low asynchronously forces: pc = RESET_VECTOR, state BOOT, RAS count and pointer 0, ras_underflow 0, halted 0.
REQ-033 RAS entry storage need not be reset; reads of unoccupied entries never select a PC.
REQ-034 Reset asserted mid-operation discards any pending redirect, push or pop.

Structure
REQ-035 State enum (BOOT, RUN, HALT) and the instruction-size constant (4) live in the shared core package.
REQ-036 RAS is one sub-module, pc_ras, with push, pop, flush, top, empty, full, underflow ports.

Verification
REQ-037 Reset release, no inputs: pc = 0, 0 (BOOT), 4, 8, 12 on successive cycles.
REQ-038 pc = 0x100, pc_src=1, imm_op=0xFFFFFFF0 -> pc = 0xF0 next cycle; simultaneous redirect_valid, redirect_pc=0x201 -> pc = 0x200 instead.
REQ-039 Call at 0x40, call at 0x80, ret, ret -> pops yield 0x84 then 0x44; ras_empty after second pop.
REQ-040 Five pushes into depth-4 RAS, then four pops -> last four return addresses in LIFO order, first push lost; fifth pop -> ras_underflow pulse, pc = pc+4.
REQ-041 stall high three cycles with is_call asserted -> pc frozen, RAS count unchanged.
REQ-042 halt_req in RUN at pc=0x20 -> halted, pc held at 0x24; redirect 0x300 while halted -> pc = 0x300, still halted; resume -> pc = 0x304 next cycle.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding and
// the fixed instruction size used for sequential fetch and link values.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Control inputs and status outputs of the PC generator. The master side
// drives fetch/execute control; the slave side is pc_gen.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) ();

    logic                     stall;
    logic                     halt_req;
    logic                     resume;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     pc_src;
    logic [ADDRESS_WIDTH-1:0] imm_op;
    logic                     is_call;
    logic                     is_ret;
    logic                     ras_flush;

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     halted;
    logic                     ras_empty;
    logic                     ras_full;
    logic                     ras_underflow;
    // FSM state exposed for observation only
    pc_state_t                state;

    modport master (
        output stall, halt_req, resume, redirect_valid, redirect_pc,
               pc_src, imm_op, is_call, is_ret, ras_flush,
        input  pc, pc_plus4, halted, ras_empty, ras_full, ras_underflow, state
    );

    modport slave (
        input  stall, halt_req, resume, redirect_valid, redirect_pc,
               pc_src, imm_op, is_call, is_ret, ras_flush,
        output pc, pc_plus4, halted, ras_empty, ras_full, ras_underflow, state
    );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. Push when full overwrites the oldest
// entry; push+pop together rewrites the popped slot in place.
module pc_ras #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int RAS_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] push_data,
    output logic [ADDRESS_WIDTH-1:0] top,
    output logic                     empty,
    output logic                     full,
    output logic                     underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            top_idx;
    logic [CW-1:0]            count;
    logic                     pop_hit;
    logic                     pop_miss;

    // ptr names the next free slot; the top of stack sits just below it
    assign top_idx  = ptr - PW'(1);
    assign top      = mem[top_idx];
    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));
    assign pop_hit  = pop & ~empty;
    assign pop_miss = pop & empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= pop_miss;
            if (flush) begin
                ptr   <= '0;
                count <= '0;
            end else if (pop_hit && !push) begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end else if (push && !pop_hit) begin
                ptr <= ptr + PW'(1);
                if (!full) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[pop_hit ? top_idx : ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT control, next-PC priority selection
// and return-address prediction through pc_ras.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter int                       RAS_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_gen_if.slave    bus
);

    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(INSN_BYTES);

    pc_state_t                state_q;
    pc_state_t                state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_inc;
    logic [ADDRESS_WIDTH-1:0] redirect_tgt;
    logic [ADDRESS_WIDTH-1:0] ras_top;
    logic [ADDRESS_WIDTH-1:0] ras_tgt;
    logic                     ras_accept;
    logic                     ras_push;
    logic                     ras_pop;
    logic                     ras_empty;
    logic                     ras_full;
    logic                     ras_underflow;
    logic                     halted;

    assign pc_inc       = pc_q + STEP;
    assign redirect_tgt = {bus.redirect_pc[ADDRESS_WIDTH-1:1], 1'b0};
    assign ras_tgt      = {ras_top[ADDRESS_WIDTH-1:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.halt_req && !bus.resume && !bus.redirect_valid) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        halted     = (state_q == ST_HALT);
        ras_accept = (state_q == ST_RUN) && !bus.stall && !bus.redirect_valid;
        ras_push   = ras_accept && bus.is_call;
        ras_pop    = ras_accept && bus.is_ret;
    end

    // Pop target is the pre-flush top, so a same-cycle flush never alters it
    always_comb begin
        pc_d = pc_q;
        unique case (state_q)
            ST_BOOT: pc_d = RESET_VECTOR;
            ST_RUN: begin
                if (bus.redirect_valid)        pc_d = redirect_tgt;
                else if (bus.stall)            pc_d = pc_q;
                else if (ras_pop && !ras_empty) pc_d = ras_tgt;
                else if (bus.pc_src)           pc_d = pc_q + bus.imm_op;
                else                           pc_d = pc_inc;
            end
            ST_HALT: begin
                if (bus.redirect_valid) pc_d = redirect_tgt;
            end
            default: pc_d = RESET_VECTOR;
        endcase
    end

    pc_ras #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RAS_DEPTH     (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (bus.ras_flush),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .underflow (ras_underflow)
    );

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_inc;
    assign bus.halted        = halted;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = ras_underflow;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/boot, a vector table for next-PC and
// RAS behaviour, and hand-written halt and mid-operation reset sequences.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_gen_if #(.ADDRESS_WIDTH(AW)) bus ();

  pc_gen #(
    .ADDRESS_WIDTH (AW),
    .RESET_VECTOR  (32'h0),
    .RAS_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          pc_src;
    logic [AW-1:0] imm_op;
    logic          is_call;
    logic          is_ret;
    logic          ras_flush;
    logic [AW-1:0] exp_pc;
    logic          exp_empty;
    logic          exp_full;
    logic          exp_uf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall          = 1'b0;
    bus.halt_req       = 1'b0;
    bus.resume         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.pc_src         = 1'b0;
    bus.imm_op         = '0;
    bus.is_call        = 1'b0;
    bus.is_ret         = 1'b0;
    bus.ras_flush      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input logic rv, input logic [AW-1:0] rpc,
                     input logic src, input logic [AW-1:0] imm,
                     input logic call, input logic ret, input logic fl,
                     input logic [AW-1:0] epc, input logic ee, input logic ef, input logic eu);
    vec_t v;
    v.stall = st; v.redirect_valid = rv; v.redirect_pc = rpc;
    v.pc_src = src; v.imm_op = imm; v.is_call = call; v.is_ret = ret; v.ras_flush = fl;
    v.exp_pc = epc; v.exp_empty = ee; v.exp_full = ef; v.exp_uf = eu;
    vecs.push_back(v);
  endtask

  // Drive one cycle of control, then compare pc and status after the edge
  task automatic step_check(input string tag, input logic [AW-1:0] epc,
                            input logic ehalt, input logic ee, input logic eu);
    exp_q.push_back(epc);
    tick();
    clear_inputs();
    check({tag, "_pc"}, bus.pc, exp_q.pop_front());
    check({tag, "_halted"}, 32'(bus.halted), 32'(ehalt));
    check({tag, "_empty"}, 32'(bus.ras_empty), 32'(ee));
    check({tag, "_uf"}, 32'(bus.ras_underflow), 32'(eu));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Vector table: {stall, redirect, redirect_pc, pc_src, imm, call, ret, flush, pc, empty, full, uf}
    add(0, 1, 32'h101,      0, 32'h0,        0, 0, 0, 32'h100,      1, 0, 0);
    add(0, 0, 32'h0,        1, 32'hFFFFFFF0, 0, 0, 0, 32'h0F0,      1, 0, 0);
    add(0, 1, 32'h201,      1, 32'h10,       0, 0, 0, 32'h200,      1, 0, 0);
    add(0, 1, 32'h40,       0, 32'h0,        0, 0, 0, 32'h40,       1, 0, 0);
    add(0, 0, 32'h0,        1, 32'h40,       1, 0, 0, 32'h80,       0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h180,      0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h84,       0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h44,       1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h48,       1, 0, 0);
    add(0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 0, 32'hFFFFFFFC, 1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0);
    add(0, 0, 32'h0,        1, 32'hFFFFFFF8, 0, 0, 0, 32'hFFFFFFF8, 1, 0, 0);
    add(0, 1, 32'h1000,     0, 32'h0,        0, 0, 0, 32'h1000,     1, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h1100,     0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h1200,     0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h1300,     0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h1400,     0, 1, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h1500,     0, 1, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1404,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1304,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1204,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1104,     1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1108,     1, 0, 1);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h110C,     1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h1110,     0, 0, 0);
    add(1, 0, 32'h0,        1, 32'h40,       1, 0, 0, 32'h1110,     0, 0, 0);
    add(1, 0, 32'h0,        1, 32'h40,       1, 0, 0, 32'h1110,     0, 0, 0);
    add(1, 0, 32'h0,        1, 32'h40,       1, 0, 0, 32'h1110,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1110,     1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h1114,     1, 0, 1);
    add(0, 1, 32'h2000,     0, 32'h0,        1, 0, 0, 32'h2000,     1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h2004,     1, 0, 1);
    add(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h2008,     0, 0, 0);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h2108,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h200C,     1, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h2010,     1, 0, 1);
    add(0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 32'h2110,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h2014,     0, 0, 0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h2114,     1, 0, 0);

    // Reset state
    #12;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_state", 32'(bus.state), 32'(ST_BOOT));
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_empty", 32'(bus.ras_empty), 32'h1);
    check("rst_full", 32'(bus.ras_full), 32'h0);
    check("rst_uf", 32'(bus.ras_underflow), 32'h0);

    // Boot: pc 0 in BOOT, 0 on entering RUN, then 4, 8, 12
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_pc0", bus.pc, 32'h0);
    tick();
    check("boot_pc1", bus.pc, 32'h0);
    check("boot_state_run", 32'(bus.state), 32'(ST_RUN));
    tick();
    check("boot_pc2", bus.pc, 32'h4);
    check("boot_plus4", bus.pc_plus4, 32'h8);
    tick();
    check("boot_pc3", bus.pc, 32'h8);
    tick();
    check("boot_pc4", bus.pc, 32'hC);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.stall          = vecs[i].stall;
      bus.redirect_valid = vecs[i].redirect_valid;
      bus.redirect_pc    = vecs[i].redirect_pc;
      bus.pc_src         = vecs[i].pc_src;
      bus.imm_op         = vecs[i].imm_op;
      bus.is_call        = vecs[i].is_call;
      bus.is_ret         = vecs[i].is_ret;
      bus.ras_flush      = vecs[i].ras_flush;
      exp_q.push_back(vecs[i].exp_pc);
      tick();
      clear_inputs();
      check($sformatf("vec%0d_pc", i), bus.pc, exp_q.pop_front());
      check($sformatf("vec%0d_plus4", i), bus.pc_plus4, vecs[i].exp_pc + 32'h4);
      check($sformatf("vec%0d_empty", i), 32'(bus.ras_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i), 32'(bus.ras_full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_uf", i), 32'(bus.ras_underflow), 32'(vecs[i].exp_uf));
    end

    // Halt sequence starting from pc 0x2114 with an empty RAS
    bus.halt_req = 1'b1; bus.resume = 1'b1;
    step_check("halt_and_resume", 32'h2118, 1'b0, 1'b1, 1'b0);
    bus.halt_req = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20;
    step_check("halt_with_redirect", 32'h20, 1'b0, 1'b1, 1'b0);
    bus.halt_req = 1'b1;
    step_check("halt_enter", 32'h24, 1'b1, 1'b1, 1'b0);
    check("halt_state", 32'(bus.state), 32'(ST_HALT));
    bus.is_call = 1'b1;
    step_check("halt_hold_call", 32'h24, 1'b1, 1'b1, 1'b0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    step_check("halt_redirect", 32'h300, 1'b1, 1'b1, 1'b0);
    step_check("halt_hold", 32'h300, 1'b1, 1'b1, 1'b0);
    bus.resume = 1'b1;
    step_check("resume", 32'h300, 1'b0, 1'b1, 1'b0);
    step_check("resume_run", 32'h304, 1'b0, 1'b1, 1'b0);
    bus.is_ret = 1'b1;
    step_check("post_halt_ret", 32'h308, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a cycle with a redirect and push pending
    bus.is_call = 1'b1;
    step_check("pre_reset_call", 32'h30C, 1'b0, 1'b0, 1'b0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h500; bus.is_call = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_state", 32'(bus.state), 32'(ST_BOOT));
    check("midrst_empty", 32'(bus.ras_empty), 32'h1);
    tick();
    check("midrst_hold_pc", bus.pc, 32'h0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_boot_pc", bus.pc, 32'h0);
    tick();
    check("midrst_run_pc", bus.pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
